// File: rtl/mips_uart_port.sv
// Memory-mapped UART for the MIPS MEM-stage data bus: TX FIFO plus 8N1 transmitter,
// with an optional receiver compiled in when UART_RX_EN is defined.
module mips_uart_port #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    input  logic        rx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [PTR_W:0]   FIFO_LIMIT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} TxState;

    logic [1:0]       regSel;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   fifoCount;
    logic             txFull;
    logic             txEmpty;
    logic             fifoPush;
    logic             fifoPop;

    TxState           txState;
    TxState           txStateNext;
    logic [CNT_W-1:0] txBaudCnt;
    logic [2:0]       txBitIdx;
    logic [7:0]       txShift;
    logic             txBaudDone;
    logic             txBusy;

    logic             rxValid;
    logic             rxOverrun;
    logic             rxFrameErr;
    logic [7:0]       rxByte;

    logic             unusedBits;

    assign regSel     = Address[3:2];
    assign unusedBits = ^{Address[1:0], WriteData[31:8]};

    assign txFull   = (fifoCount == FIFO_LIMIT);
    assign txEmpty  = (fifoCount == '0);
    assign fifoPush = MemWrite && (regSel == REG_TXDATA) && !txFull;

    // Storage carries no reset; the flush on reset comes from clearing pointers and count.
    always_ff @(posedge clk) begin
        if (fifoPush)
            fifoMem[wrPtr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (fifoPush)
                wrPtr <= wrPtr + 1'b1;
            if (fifoPop)
                rdPtr <= rdPtr + 1'b1;
            case ({fifoPush, fifoPop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    assign txBaudDone = (txBaudCnt == BAUD_LAST);
    assign txBusy     = (txState != TX_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            txState <= TX_IDLE;
        else
            txState <= txStateNext;
    end

    // STOP chains straight into START when another byte is waiting, so bursts have no idle gap.
    always_comb begin
        txStateNext = txState;
        fifoPop     = 1'b0;
        tx          = 1'b1;
        case (txState)
            TX_IDLE: begin
                if (!txEmpty) begin
                    fifoPop     = 1'b1;
                    txStateNext = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (txBaudDone)
                    txStateNext = TX_DATA;
            end
            TX_DATA: begin
                tx = txShift[0];
                if (txBaudDone && (txBitIdx == 3'd7))
                    txStateNext = TX_STOP;
            end
            TX_STOP: begin
                if (txBaudDone) begin
                    if (!txEmpty) begin
                        fifoPop     = 1'b1;
                        txStateNext = TX_START;
                    end else begin
                        txStateNext = TX_IDLE;
                    end
                end
            end
            default: txStateNext = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txBaudCnt <= '0;
            txBitIdx  <= '0;
            txShift   <= '0;
        end else begin
            if ((txState == TX_IDLE) || txBaudDone)
                txBaudCnt <= '0;
            else
                txBaudCnt <= txBaudCnt + 1'b1;

            if (txState != TX_DATA)
                txBitIdx <= '0;
            else if (txBaudDone)
                txBitIdx <= txBitIdx + 3'd1;

            if (fifoPop)
                txShift <= fifoMem[rdPtr];
            else if ((txState == TX_DATA) && txBaudDone)
                txShift <= {1'b0, txShift[7:1]};
        end
    end

`ifdef UART_RX_EN
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} RxState;

    RxState           rxState;
    RxState           rxStateNext;
    logic             rxMeta;
    logic             rxSync;
    logic             rxPrev;
    logic [CNT_W-1:0] rxBaudCnt;
    logic [2:0]       rxBitIdx;
    logic [7:0]       rxShift;
    logic             rxSampleBit;
    logic             rxDone;
    logic             rxStopBad;
    logic             rxDataRead;
    logic             statusRead;

    assign rxDataRead = MemRead && (regSel == REG_RXDATA);
    assign statusRead = MemRead && (regSel == REG_STATUS);

    // rxPrev lets IDLE act on a genuine high-to-low transition rather than a line held low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rxState <= RX_IDLE;
        else
            rxState <= rxStateNext;
    end

    always_comb begin
        rxStateNext = rxState;
        rxSampleBit = 1'b0;
        rxDone      = 1'b0;
        rxStopBad   = 1'b0;
        case (rxState)
            RX_IDLE: begin
                if (rxPrev && !rxSync)
                    rxStateNext = RX_START;
            end
            RX_START: begin
                if (rxBaudCnt == HALF_LAST)
                    rxStateNext = rxSync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rxBaudCnt == BAUD_LAST) begin
                    rxSampleBit = 1'b1;
                    if (rxBitIdx == 3'd7)
                        rxStateNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rxBaudCnt == BAUD_LAST) begin
                    rxStateNext = RX_IDLE;
                    rxDone      = rxSync;
                    rxStopBad   = !rxSync;
                end
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxBaudCnt <= '0;
            rxBitIdx  <= '0;
            rxShift   <= '0;
        end else begin
            if ((rxState == RX_IDLE) || (rxStateNext != rxState) || (rxBaudCnt == BAUD_LAST))
                rxBaudCnt <= '0;
            else
                rxBaudCnt <= rxBaudCnt + 1'b1;

            if (rxState != RX_DATA)
                rxBitIdx <= '0;
            else if (rxSampleBit)
                rxBitIdx <= rxBitIdx + 3'd1;

            if (rxSampleBit)
                rxShift <= {rxSync, rxShift[7:1]};
        end
    end

    // A completing byte beats a same-edge RXDATA read, and set events beat STATUS-read clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxByte     <= '0;
            rxValid    <= 1'b0;
            rxOverrun  <= 1'b0;
            rxFrameErr <= 1'b0;
        end else begin
            if (rxDone && (!rxValid || rxDataRead)) begin
                rxByte  <= rxShift;
                rxValid <= 1'b1;
            end else if (rxDataRead) begin
                rxValid <= 1'b0;
            end

            if (rxDone && rxValid && !rxDataRead)
                rxOverrun <= 1'b1;
            else if (statusRead)
                rxOverrun <= 1'b0;

            if (rxStopBad)
                rxFrameErr <= 1'b1;
            else if (statusRead)
                rxFrameErr <= 1'b0;
        end
    end
`else
    logic unusedRx;

    assign unusedRx   = ^{rx, MemRead};
    assign rxByte     = 8'h00;
    assign rxValid    = 1'b0;
    assign rxOverrun  = 1'b0;
    assign rxFrameErr = 1'b0;
`endif

    always_comb begin
        ReadData = '0;
        case (regSel)
            REG_STATUS: ReadData = {26'b0, rxFrameErr, txBusy, rxOverrun, rxValid, txEmpty, txFull};
            REG_RXDATA: ReadData = {24'b0, rxByte};
            default:    ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_mips_uart_port.sv
// Directed bench for mips_uart_port with BAUD_DIV=4, FIFO_DEPTH=8; receiver checks run
// only when UART_RX_EN is defined.
module tb_mips_uart_port;

    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 8;

    typedef struct {
        string       name;
        logic [3:0]  addr;
        logic [31:0] expData;
    } RegVec;

    typedef struct {
        logic [7:0] data;
        logic [9:0] expFrame;
    } FrameVec;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        rx;
    logic        rxDrive;
    logic        rxLoop;

    int checkCount = 0;
    int errorCount = 0;

    assign rx = rxLoop ? tx : rxDrive;

    mips_uart_port #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx        (tx),
        .rx        (rx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One bus cycle; the upper data bits are junk that the peripheral must ignore.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] addr, input logic [7:0] data);
        Address   = addr;
        MemWrite  = wr;
        MemRead   = rd;
        WriteData = {24'hC0FFEE, data};
        tick();
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
        Address  = addr;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        #1;
        data = ReadData;
    endtask

    // Entered on the first cycle of START; every cycle must show busy and the expected line level.
    task automatic checkFrame(input string name, input logic [9:0] expFrame);
        Address = 4'h4;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < BAUD_DIV; j++) begin
                checkOutput($sformatf("%s bit%0d cyc%0d {busy,tx}", name, i, j),
                            {30'b0, ReadData[4], tx}, {30'b0, 1'b1, expFrame[i]});
                tick();
            end
        end
    endtask

    task automatic expectIdle(input string name, input int cycles);
        Address = 4'h4;
        for (int k = 0; k < cycles; k++) begin
            checkOutput($sformatf("%s cyc%0d {busy,tx}", name, k), {30'b0, ReadData[4], tx}, 32'h1);
            tick();
        end
    endtask

    task automatic sendRxFrame(input logic [7:0] data, input logic stopBit);
        logic [9:0] bits;
        bits = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxDrive = bits[i];
            repeat (BAUD_DIV) tick();
        end
        rxDrive = 1'b1;
    endtask

    initial begin
        RegVec       resetVecs [6];
        FrameVec     frameVecs [4];
        logic [31:0] rd;

        resetVecs[0] = '{name: "txdata reads 0",      addr: 4'h0, expData: 32'h0};
        resetVecs[1] = '{name: "status after reset",  addr: 4'h4, expData: 32'h2};
        resetVecs[2] = '{name: "status low bits",     addr: 4'h7, expData: 32'h2};
        resetVecs[3] = '{name: "rxdata after reset",  addr: 4'h8, expData: 32'h0};
        resetVecs[4] = '{name: "offset 3 reads 0",    addr: 4'hC, expData: 32'h0};
        resetVecs[5] = '{name: "txdata low bits",     addr: 4'h1, expData: 32'h0};

        frameVecs[0] = '{data: 8'hA5, expFrame: 10'b1101001010};
        frameVecs[1] = '{data: 8'h3C, expFrame: 10'b1001111000};
        frameVecs[2] = '{data: 8'h00, expFrame: 10'b1000000000};
        frameVecs[3] = '{data: 8'hFF, expFrame: 10'b1111111110};

        reset     = 1'b1;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 4'h0;
        WriteData = 32'h0;
        rxDrive   = 1'b1;
        rxLoop    = 1'b0;
        repeat (3) tick();
        checkOutput("tx during reset", {31'b0, tx}, 32'h1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            readReg(resetVecs[i].addr, rd);
            checkOutput(resetVecs[i].name, rd, resetVecs[i].expData);
        end
        checkOutput("tx idle after reset", {31'b0, tx}, 32'h1);

        // Single frames: push at edge N, tx still high after N, START from N+1.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, frameVecs[i].data);
            checkOutput($sformatf("frame%0d tx before pop", i), {31'b0, tx}, 32'h1);
            readReg(4'h4, rd);
            checkOutput($sformatf("frame%0d status after push", i), rd, 32'h00);
            tick();
            checkFrame($sformatf("frame%0d", i), frameVecs[i].expFrame);
            readReg(4'h4, rd);
            checkOutput($sformatf("frame%0d status after frame", i), rd, 32'h02);
            checkOutput($sformatf("frame%0d tx after frame", i), {31'b0, tx}, 32'h1);
        end

        // A 0xFF carrier frame keeps the transmitter busy so 0x01..0x08 fill the FIFO.
        applyStimulus(1'b1, 1'b0, 4'h0, 8'hFF);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, 8'(k));
            readReg(4'h4, rd);
            checkOutput($sformatf("fill store%0d status", k), rd, (k == 8) ? 32'h11 : 32'h10);
        end
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h09);
        readReg(4'h4, rd);
        checkOutput("store on full status", rd, 32'h11);
        repeat (32) tick();
        for (int k = 1; k <= 8; k++) begin
            checkFrame($sformatf("burst byte%0d", k), {1'b1, 8'(k), 1'b0});
        end
        readReg(4'h4, rd);
        checkOutput("status after burst", rd, 32'h02);
        expectIdle("no dropped byte sent", 60);

        // Reset mid-frame with a second byte queued.
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h55);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h66);
        checkOutput("midframe tx start bit", {31'b0, tx}, 32'h0);
        tick();
        reset = 1'b1;
        #1;
        checkOutput("midframe reset tx", {31'b0, tx}, 32'h1);
        readReg(4'h4, rd);
        checkOutput("midframe reset status", rd, 32'h02);
        repeat (2) tick();
        reset = 1'b0;
        expectIdle("after midframe reset", 60);

`ifdef UART_RX_EN
        rxLoop = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h3C);
        repeat (60) tick();
        readReg(4'h4, rd);
        checkOutput("loopback status", rd, 32'h06);
        readReg(4'h8, rd);
        checkOutput("loopback rxdata", rd, 32'h3C);
        applyStimulus(1'b0, 1'b1, 4'h8, 8'h00);
        readReg(4'h4, rd);
        checkOutput("rxdata read clears valid", rd, 32'h02);

        applyStimulus(1'b1, 1'b0, 4'h0, 8'h11);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h22);
        repeat (110) tick();
        readReg(4'h8, rd);
        checkOutput("overrun keeps first byte", rd, 32'h11);
        readReg(4'h4, rd);
        checkOutput("overrun status", rd, 32'h0E);
        applyStimulus(1'b0, 1'b1, 4'h4, 8'h00);
        readReg(4'h4, rd);
        checkOutput("status read clears overrun", rd, 32'h06);
        applyStimulus(1'b0, 1'b1, 4'h8, 8'h00);
        readReg(4'h4, rd);
        checkOutput("second rxdata read clears valid", rd, 32'h02);
        rxLoop = 1'b0;

        sendRxFrame(8'h5A, 1'b0);
        repeat (10) tick();
        readReg(4'h4, rd);
        checkOutput("frame error status", rd, 32'h22);
        readReg(4'h8, rd);
        checkOutput("frame error discards byte", rd, 32'h11);
        applyStimulus(1'b0, 1'b1, 4'h4, 8'h00);
        readReg(4'h4, rd);
        checkOutput("status read clears frame error", rd, 32'h02);

        rxDrive = 1'b0;
        repeat (BAUD_DIV / 2 - 1) tick();
        rxDrive = 1'b1;
        repeat (50) tick();
        readReg(4'h4, rd);
        checkOutput("glitch status unchanged", rd, 32'h02);
        readReg(4'h8, rd);
        checkOutput("glitch rxdata unchanged", rd, 32'h11);
`else
        sendRxFrame(8'h3C, 1'b1);
        repeat (10) tick();
        applyStimulus(1'b0, 1'b1, 4'h4, 8'h00);
        readReg(4'h4, rd);
        checkOutput("rx disabled status", rd, 32'h02);
        readReg(4'h8, rd);
        checkOutput("rx disabled rxdata", rd, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mips_uart_port.md
# mips_uart_port

Memory-mapped UART peripheral sitting directly downstream of the MIPS processor's MEM stage, on the same data bus as the data RAM. Store words to its address window push bytes into a TX FIFO that is serialized on `tx`. Load words return status or the last received byte. Loads and stores use the same Address/MemWrite/MemRead/WriteData/ReadData handshake as the data memory, so the MEM stage needs no changes beyond address decode.

## Interface
- `BAUD_DIV`, default 434: clock cycles per serial bit (50 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Power of two, ≥ 2.
- `clk` in, 1: single clock, rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `Address` in, 4: byte offset. Only bits [3:2] are decoded.
- `MemWrite` in, 1: store strobe, sampled at the rising edge.
- `MemRead` in, 1: load strobe. Side effects apply at the rising edge.
- `WriteData` in, 32: store data. Bits [7:0] are used.
- `ReadData` out, 32: combinational from registered state and `Address`.
- `tx` out, 1: serial output, idle high.
- `rx` in, 1: serial input, asynchronous to `clk`.

## Operation
- Register map, selected by `Address[3:2]`:
  - 0 = TXDATA: write only; reads 0.
  - 1 = STATUS: read only.
  - 2 = RXDATA: read only; `ReadData = {24'b0, rx_byte}`.
  - 3: reads 0; writes ignored.
- STATUS bits: [0] tx_full, [1] tx_empty, [2] rx_valid, [3] rx_overrun, [4] tx_busy (FSM not IDLE), [5] rx_frame_err. Bits [31:6] are 0.
- Write to TXDATA when not full: pushes `WriteData[7:0]`. When full: the byte is dropped and nothing changes.
  - Full is evaluated before the edge, so a push on full is dropped even if a pop happens in the same cycle.
- Push and pop in the same cycle with the FIFO neither full nor empty: count is unchanged, and both the data and the pointers advance.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. A count of 0..FIFO_DEPTH derives full and empty.
- TX FSM, frame is 8N1 with data LSB first:
  - IDLE: `tx`=1. When the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for BAUD_DIV cycles, then DATA.
  - DATA: shift out 8 bits, BAUD_DIV cycles each, bit index 0..7, then STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles, then IDLE.
- RX path:
  - `rx` passes through a 2-flop synchronizer.
  - IDLE: a synchronized falling edge starts reception.
  - At BAUD_DIV/2 cycles the line must still be low; otherwise return to IDLE (glitch rejected).
  - Then sample 8 data bits, each BAUD_DIV cycles apart, then the stop bit.
  - Stop bit = 0: set rx_frame_err and discard the byte.
  - Stop bit = 1 with rx_valid=0: load rx_byte and set rx_valid.
  - Stop bit = 1 with rx_valid=1: set rx_overrun and discard the new byte; rx_byte is kept.
- Read of RXDATA with `MemRead`: clears rx_valid at that edge. If a new byte completes on the same edge, the new byte loads and rx_valid stays 1.
- Read of STATUS with `MemRead`: clears rx_overrun and rx_frame_err at that edge. A same-edge set event wins.

## Timing
- Reset values:
  - `tx`=1 and `ReadData` reflects cleared state: STATUS reads 0x02.
  - FIFO empty, pointers 0, both FSMs IDLE, baud counters 0.
  - rx_byte=0, all flags 0.
- Reset asserted mid-frame: `tx` goes to 1 immediately, the FIFO is flushed, and no partial byte is retained.
- Store → `tx` falls: 2 cycles. The push occurs at edge N, the FSM pops at edge N+1, and `tx`=0 is driven from N+1.
- One frame lasts 10·BAUD_DIV cycles. Back-to-back FIFO bytes have no idle gap: STOP goes straight to START if the FIFO is non-empty.
- `rx` stop-bit sample → rx_valid visible in STATUS: 1 cycle after the sample edge, plus 2 cycles of synchronizer latency relative to the pin.
- `ReadData` has zero-cycle latency: it is combinational. The MEM/WB register in the processor captures it.

## Configuration
- `UART_RX_EN` defined: the receiver, synchronizer and RXDATA are compiled in.
- `UART_RX_EN` undefined: the receiver is removed.
  - `rx` is unused.
  - RXDATA reads 0, and STATUS bits [3:2] and [5] are constant 0.
  - TX behaviour is identical in both builds.

## Test plan
- Reset check: reset mid-frame → `tx`=1 within the same cycle, STATUS=0x02, and after release no further frame is sent.
- Single byte: store 0xA5 to offset 0, BAUD_DIV=4 → `tx` sequence is 0,1,0,1,0,0,1,0,1,1 (each bit 4 cycles), and tx_busy=1 for 40 cycles.
- FIFO full: 9 stores of 0x01..0x09 with FIFO_DEPTH=8, back-to-back while the first is still in the FIFO:
  - STATUS bit0=1 after the 8th store.
  - 0x09 is dropped.
  - Output bytes are 0x01..0x08, contiguous with no idle bits.
- RX loopback (`UART_RX_EN` defined, `rx` tied to `tx`), store 0x3C:
  - After the frame, STATUS bit2=1 and RXDATA=0x3C.
  - Reading RXDATA clears bit2.
- Overrun and frame error:
  - Two frames 0x11, 0x22 received without a read → RXDATA=0x11 and STATUS bit3=1; a STATUS read clears bit3.
  - A frame with stop bit 0 → bit5=1 and rx_valid unchanged.
- Glitch rejection: `rx` low for BAUD_DIV/2−1 cycles → no reception and STATUS unchanged.
